// File: rtl/mul_pkg.sv
// Shared definitions for the multiplication unit.
// Contents: default operand width, 2-bit op type and its RISC-V M-extension encodings,
// and a helper that tells whether an op returns the high product half.
package mul_pkg;

    localparam int unsigned MUL_XLEN_DEFAULT = 32;

    typedef logic [1:0] mul_op_t;

    localparam mul_op_t MUL_OP_MUL    = 2'b00;
    localparam mul_op_t MUL_OP_MULH   = 2'b01;
    localparam mul_op_t MUL_OP_MULHSU = 2'b10;
    localparam mul_op_t MUL_OP_MULHU  = 2'b11;

    // Signedness is resolved before the compressor tree, so every op except MUL
    // simply selects the upper half of the product.
    function automatic logic mul_op_is_high(mul_op_t op);
        return op != MUL_OP_MUL;
    endfunction

endpackage

// File: rtl/mul_cpa_half.sv
// W-bit carry-propagate adder with carry-in and carry-out.
// Ports:
//   a_i, b_i  operands
//   ci_i      carry in
//   sum_o     W-bit sum
//   co_o      carry out
module mul_cpa_half #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] sum_o,
    output logic         co_o
);

    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};

endmodule

// File: rtl/mul_cpa_stage.sv
// Final carry-propagate stage of the multiplier: adds the redundant sum/carry pair from the
// compressor tree into the 2*XLEN-bit product and returns the low (MUL) or high
// (MULH/MULHSU/MULHU) half with its destination tag over valid/ready.
// Build option MUL_CPA_SPLIT_EN: defined -> two-stage split add (latency 2);
// undefined -> single-stage full add (latency 1).
// Ports:
//   CLK, rst_n         clock, asynchronous active-low reset
//   valid_i / ready_o  input handshake for sum_i, carry_i, op_i, tag_i
//   sum_i, carry_i     redundant product (carry has weight 2); bit 2*XLEN is ignored
//   op_i, tag_i        M-extension op and destination tag
//   flush_i            drops all in-flight work and any input offered this cycle
//   valid_o / ready_i  output handshake for result_o, tag_o
module mul_cpa_stage
    import mul_pkg::*;
#(
    parameter int unsigned XLEN  = MUL_XLEN_DEFAULT,
    parameter int unsigned TAG_W = 5
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2*XLEN:0]  sum_i,
    input  logic [2*XLEN:0]  carry_i,
    input  mul_op_t          op_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    // Bits that fall outside the 2*XLEN-bit product after the carry shift.
    logic unused_top;
    assign unused_top = ^{sum_i[2*XLEN], carry_i[2*XLEN:2*XLEN-1]};

    logic accept;

`ifdef MUL_CPA_SPLIT_EN

    logic [XLEN-1:0]  lo_sum;
    logic             lo_co;
    logic [XLEN-1:0]  hi_sum;
    logic             unused_hi_co;

    logic             s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]  s1_lo_q, s1_sum_hi_q, s1_carry_hi_q;
    logic             s1_c_q;
    mul_op_t          s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s2_free;
    logic             s1_move;

    mul_cpa_half #(.W(XLEN)) u_lo (
        .a_i   (sum_i[XLEN-1:0]),
        .b_i   ({carry_i[XLEN-2:0], 1'b0}),
        .ci_i  (1'b0),
        .sum_o (lo_sum),
        .co_o  (lo_co)
    );

    // Upper half: carry bit XLEN-1 lands on product bit XLEN after the shift.
    mul_cpa_half #(.W(XLEN)) u_hi (
        .a_i   (s1_sum_hi_q),
        .b_i   (s1_carry_hi_q),
        .ci_i  (s1_c_q),
        .sum_o (hi_sum),
        .co_o  (unused_hi_co)
    );

    always_comb begin
        s2_free     = !s2_valid_q | ready_i;
        ready_o     = !s1_valid_q | s2_free;
        accept      = valid_i & ready_o & !flush_i;
        s1_move     = s1_valid_q & s2_free;

        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;

        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s1_move) begin
                s1_valid_d = 1'b0;
            end
            if (s1_move) begin
                s2_valid_d  = 1'b1;
                s2_result_d = mul_op_is_high(s1_op_q) ? hi_sum : s1_lo_q;
                s2_tag_d    = s1_tag_q;
            end else if (ready_i) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_lo_q       <= '0;
            s1_c_q        <= 1'b0;
            s1_sum_hi_q   <= '0;
            s1_carry_hi_q <= '0;
            s1_op_q       <= MUL_OP_MUL;
            s1_tag_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_result_q   <= '0;
            s2_tag_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
            if (accept) begin
                s1_lo_q       <= lo_sum;
                s1_c_q        <= lo_co;
                s1_sum_hi_q   <= sum_i[2*XLEN-1:XLEN];
                s1_carry_hi_q <= carry_i[2*XLEN-2:XLEN-1];
                s1_op_q       <= op_i;
                s1_tag_q      <= tag_i;
            end
        end
    end

    assign valid_o  = s2_valid_q;
    assign result_o = s2_result_q;
    assign tag_o    = s2_tag_q;

`else

    logic [2*XLEN-1:0] carry_sh;
    logic [XLEN-1:0]   lo_sum, hi_sum;
    logic              lo_co;
    logic              unused_hi_co;

    logic              s_valid_q, s_valid_d;
    logic [XLEN-1:0]   s_result_q, s_result_d;
    logic [TAG_W-1:0]  s_tag_q, s_tag_d;

    assign carry_sh = {carry_i[2*XLEN-2:0], 1'b0};

    mul_cpa_half #(.W(XLEN)) u_lo (
        .a_i   (sum_i[XLEN-1:0]),
        .b_i   (carry_sh[XLEN-1:0]),
        .ci_i  (1'b0),
        .sum_o (lo_sum),
        .co_o  (lo_co)
    );

    mul_cpa_half #(.W(XLEN)) u_hi (
        .a_i   (sum_i[2*XLEN-1:XLEN]),
        .b_i   (carry_sh[2*XLEN-1:XLEN]),
        .ci_i  (lo_co),
        .sum_o (hi_sum),
        .co_o  (unused_hi_co)
    );

    always_comb begin
        ready_o    = !s_valid_q | ready_i;
        accept     = valid_i & ready_o & !flush_i;
        s_valid_d  = s_valid_q;
        s_result_d = s_result_q;
        s_tag_d    = s_tag_q;

        if (flush_i) begin
            s_valid_d = 1'b0;
        end else if (accept) begin
            s_valid_d  = 1'b1;
            s_result_d = mul_op_is_high(op_i) ? hi_sum : lo_sum;
            s_tag_d    = tag_i;
        end else if (ready_i) begin
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_q  <= 1'b0;
            s_result_q <= '0;
            s_tag_q    <= '0;
        end else begin
            s_valid_q  <= s_valid_d;
            s_result_q <= s_result_d;
            s_tag_q    <= s_tag_d;
        end
    end

    assign valid_o  = s_valid_q;
    assign result_o = s_result_q;
    assign tag_o    = s_tag_q;

`endif

endmodule

// File: doc/mul_cpa_stage.md
# mul_cpa_stage

Carry-propagate (final-addition) stage of the multiplication unit. It sits directly downstream of the 4:2 compressor tree and takes the redundant sum/carry pair the tree produces. It adds the pair into the 2·XLEN-bit product and selects the low or high XLEN half per the RISC-V M-extension opcode. It returns the result with its destination tag over a valid/ready handshake, with stall and flush support.

## Interface
- XLEN, default 32: operand width; the product is 2·XLEN bits.
- TAG_W, default 5: width of the destination-register tag.
- CLK  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  sum_i/carry_i/op_i/tag_i are valid this cycle.
- ready_o  out  1  stage accepts input this cycle.
- sum_i  in  2·XLEN+1  sum vector from the compressor tree, weight 1.
- carry_i  in  2·XLEN+1  carry vector from the compressor tree, weight 2.
- op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- tag_i  in  TAG_W  destination tag, passed through unchanged.
- flush_i  in  1  discards all in-flight operations.
- valid_o  out  1  result_o/tag_o are valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  selected product half.
- tag_o  out  TAG_W  tag of the result.

## Operation
- Product P = (sum_i + (carry_i << 1)) mod 2^(2·XLEN). Bit 2·XLEN of both inputs and all carries out of bit 2·XLEN−1 are discarded.
- Signedness is resolved upstream, so MULH, MULHSU and MULHU all return P[2·XLEN−1:XLEN]. MUL returns P[XLEN−1:0].
- Pipeline, two stages:
  - S1 registers the operation. It adds the low halves, lo = sum[XLEN−1:0] + {carry[XLEN−2:0],0}, and registers lo[XLEN−1:0], the carry-out c, the upper operand halves, op and tag.
  - S2 computes hi = sum[2X−1:X] + carry[2X−2:X−1] + c. It drives result_o from lo or hi according to op.
- Each stage holds one valid bit. A stage advances when the next stage is empty or is being drained in the same cycle.
- ready_o = !s1_valid | (!s2_valid | ready_i). ready_o is combinational and does not depend on valid_i.
- An input transfers on valid_i & ready_o. An output transfers on valid_o & ready_i.
- While valid_o=1 and ready_i=0, result_o and tag_o hold stable.
- flush_i clears both valid bits at the next edge. An input presented in a flush cycle is dropped. Flush has priority over accept.
- Reset clears s1_valid and s2_valid asynchronously. valid_o=0 during and after reset. result_o and tag_o reset to 0. ready_o=1 after reset.

## Timing
- Latency 2 cycles: an input accepted at edge N gives valid_o=1 after edge N+1.
- Throughput is 1 result per cycle while ready_i=1.
- Back-to-back ops with ready_i low fill both stages, then ready_o drops. No loss or duplication occurs.
- Simultaneous output drain and input accept in a full pipe: both transfer, and occupancy is unchanged.
- Reset mid-operation discards all work. No partial result appears after rst_n rises.

## Configuration
- MUL_CPA_SPLIT_EN:
  - Defined: the two-stage split adder described above, with latency 2.
  - Undefined: a single stage performs the full 2·XLEN-bit add and selection in one cycle, with latency 1. ready_o = !s_valid | ready_i. Flush and reset rules are unchanged.

## Structure
- Shared package mul_pkg holds:
  - op encodings MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU;
  - a typedef for the 2-bit op;
  - the default XLEN constant.
- One sub-module, mul_cpa_half: an XLEN-bit adder with carry-in and carry-out, instantiated once per half.

## Test plan
- MUL 3×5: sum_i=15, carry_i=0, op=00, tag=7 → two cycles later valid_o=1, result_o=0x0000000F, tag_o=7.
- Cross-half carry: sum_i=0x0_0000_0000_FFFF_FFFF, carry_i=1, op=11 → result_o=0x00000001. The same input with op=00 → result_o=0x00000001.
- Discarded bit 64: sum_i=0x1_0000_0000_0000_0002, carry_i=0, op=00 → result_o=2. With op=01 → result_o=0.
- Backpressure: issue 3 ops with ready_i=0 → ready_o falls after 2 accepts and outputs hold stable. Raise ready_i → results emerge in order with no gaps or duplicates.
- Flush: flush_i with 2 ops in flight and valid_i=1 → the next cycle valid_o=0. None of the three results ever appears.
- Reset mid-operation: assert rst_n=0 asynchronously with 2 ops in flight → valid_o=0 immediately and result_o=0. After release, ready_o=1 and no stale results appear.
